fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 fifo_empty  input  1  FIFO empty flag, high means no byte available.
REQ-005 fifo_data  input  8  FIFO read data, valid on the cycle after fifo_rd is high.
REQ-006 fifo_rd  output  1  FIFO pop strobe, one cycle per byte.
REQ-007 tx  output  1  serial line: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, START, DATA and STOP.
REQ-011 IDLE: fifo_rd SHALL be high combinationally iff state is IDLE, fifo_empty is 0 and rst is 0.
REQ-012 IDLE: when fifo_rd is high, the FSM SHALL go to FETCH; otherwise it stays in IDLE.
REQ-013 FETCH: lasts exactly 1 cycle; the FSM SHALL capture fifo_data into an 8-bit shift register and go to START.
REQ-014 START: tx SHALL be 0 for exactly CLKS_PER_BIT cycles, then the FSM goes to DATA.
REQ-015 DATA: tx SHALL present shift-register bit 0 for CLKS_PER_BIT cycles per bit, shifting right between bits.
REQ-016 DATA: a 3-bit index counts 0..7; after bit 7 the FSM SHALL go to STOP.
REQ-017 STOP: tx SHALL be 1 for CLKS_PER_BIT cycles, and tx_done SHALL be high on the final cycle only.
REQ-018 Final STOP cycle with fifo_empty=0: fifo_rd SHALL be high and the FSM SHALL go directly to FETCH (back-to-back).
REQ-019 Final STOP cycle with fifo_empty=1: the FSM SHALL go to IDLE.
REQ-020 tx SHALL be 1 in IDLE and FETCH, so back-to-back frames are separated by exactly one idle-high cycle.
REQ-021 fifo_rd SHALL never be high while fifo_empty is 1, and SHALL be high at most once per frame.
REQ-022 fifo_empty changing after the FETCH cycle SHALL have no effect on the frame in progress.
REQ-023 Bit-timing counter: width $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on every state entry.
REQ-024 Frame length from the fifo_rd cycle to the tx_done cycle SHALL be 2 + 10*CLKS_PER_BIT - 1 cycles inclusive.
REQ-025 tx, busy and tx_done SHALL be registered, glitch-free outputs; fifo_rd is the only combinational output.

Reset
REQ-026 While rst is high: state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd=0, shift register=0, counters=0.
REQ-027 rst asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, no tx_done, and the popped byte is discarded.
REQ-028 After rst deasserts, a non-empty FIFO SHALL be popped in the first cycle that is out of reset.

Structure
REQ-029 A shared package SHALL hold the state enum, DATA_BITS=8, START_BIT=1'b0 and STOP_BIT=1'b1.
REQ-030 The bit-timing counter SHALL be one sub-module, tx_baud_counter (inputs clear and enable; output bit_end pulse).
REQ-031 The FSM, shift register and bit index SHALL live in fifo_uart_tx.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-032 Reset: rst high for 3 cycles with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout; fifo_rd=1 on the first cycle after release.
REQ-033 Single byte 0xA5: one fifo_rd pulse at cycle 0; FETCH at cycle 1; from cycle 2, tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done only at cycle 41; IDLE at cycle 42.
REQ-034 Back-to-back 0x00 then 0xFF with fifo_empty=0: second fifo_rd in the first frame's tx_done cycle; exactly one tx=1 cycle (FETCH) before the second start bit; exactly 2 fifo_rd pulses total.
REQ-035 fifo_empty=1 held for 100 cycles -> fifo_rd, busy and tx_done stay 0, and tx stays 1.
REQ-036 rst pulsed during data bit 3 of 0x3C -> tx=1 and busy=0 on the next cycle, no tx_done; the next FIFO byte transmits cleanly.
REQ-037 CLKS_PER_BIT=2, byte 0x81 -> each bit lasts 2 cycles and tx_done occurs 21 cycles after fifo_rd.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-timing counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit (plus the cycle before it, for registered look-ahead).
module tx_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  // Not gated by clear_i: the FSM derives its clear from this pulse.
  assign bit_end_o     = enable_i && (cnt_q == LAST);
  assign bit_pre_end_o = enable_i && (cnt_q == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO and sends 8N1 frames,
// supporting back-to-back frames separated by a single idle-high cycle.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end, bit_pre_end;
  logic                 cnt_clear, cnt_en;

  tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i        (clk),
    .clear_i      (cnt_clear),
    .enable_i     (cnt_en),
    .bit_end_o    (bit_end),
    .bit_pre_end_o(bit_pre_end)
  );

  // Next state, pop strobe and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    fifo_rd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !rst) begin
          fifo_rd = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        shreg_d = fifo_data;
        idx_d   = 3'd0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty && !rst) begin
            fifo_rd = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_en    = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    cnt_clear = rst || (state_d != state_q);

    unique case (state_d)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = STOP_BIT;
    endcase
    busy_d = (state_d != ST_IDLE);
    // One cycle early so the registered pulse lands on the last stop cycle.
    done_d = (state_q == ST_STOP) && bit_pre_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= 3'd0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
